uart_parity_unit: RTL and testbench

//   Parametrised parity engine for the UART datapath. The TX side computes a registered

---
 rtl/uart_parity_unit.sv | 154 +++++++++++++++
 tb/tb_uart_parity_unit.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_parity_unit.sv
// Parity engine for the UART datapath: registered TX parity, serial RX parity check.
// Latency: tx_par/tx_par_vld 1 cycle after tx_ld; rx_done/rx_par_err 1 cycle after final bit.
// Backpressure: none; inputs are qualified by tx_ld / rx_bit_vld and are always accepted.
//
// Ports:
//   clk, rst_n           clock and synchronous active-low reset
//   mode                 000 none, 001 even, 010 odd, 011 mark, 100 space, 101-111 none
//   tx_ld, tx_data       load a parallel word; tx_par (held) and tx_par_vld (pulse) follow
//   rx_start             start or restart a received frame
//   rx_bit_vld, rx_bit   one serial bit per strobe, LSB first, data bits then parity bit
//   rx_busy              frame in progress
//   rx_done, rx_par_err  one-cycle pulses at the end of a frame
//   err_cnt              saturating parity-error count
//
// Optional feature: define UART_PAR_ERR_CNT_EN to build the parity-error counter;
// otherwise err_cnt is tied to zero.
module uart_parity_unit #(
  parameter int DATA_WIDTH = 8,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [2:0]            mode,
  input  logic                  tx_ld,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_par,
  output logic                  tx_par_vld,
  input  logic                  rx_start,
  input  logic                  rx_bit_vld,
  input  logic                  rx_bit,
  output logic                  rx_busy,
  output logic                  rx_done,
  output logic                  rx_par_err,
  output logic [ERR_CNT_W-1:0]  err_cnt
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2
  } state_t;

  // Expected parity bit given the XOR reduction of the data bits.
  function automatic logic par_of(input logic [2:0] m, input logic x);
    case (m)
      3'b001:  return x;
      3'b010:  return ~x;
      3'b011:  return 1'b1;
      3'b100:  return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic is_none(input logic [2:0] m);
    return (m == 3'b000) || (m > 3'b100);
  endfunction

  // ---------------- TX ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_par     <= 1'b1;
      tx_par_vld <= 1'b0;
    end else begin
      tx_par_vld <= tx_ld;
      if (tx_ld) begin
        tx_par <= par_of(mode, ^tx_data);
      end
    end
  end

  // ---------------- RX ----------------
  state_t           state_q, state_d;
  logic             acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       mode_q, mode_d;
  logic             done_d, perr_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      acc_q      <= 1'b0;
      cnt_q      <= '0;
      mode_q     <= 3'b000;
      rx_done    <= 1'b0;
      rx_par_err <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      mode_q     <= mode_d;
      rx_done    <= done_d;
      rx_par_err <= perr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    perr_d  = 1'b0;
    // rx_start has priority in every state; a coincident bit is dropped.
    if (rx_start) begin
      state_d = DATA;
      acc_d   = 1'b0;
      cnt_d   = '0;
      mode_d  = mode;
    end else if (rx_bit_vld) begin
      case (state_q)
        DATA: begin
          acc_d = acc_q ^ rx_bit;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
            if (is_none(mode_q)) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = PAR;
            end
          end
        end
        PAR: begin
          done_d  = 1'b1;
          perr_d  = (rx_bit != par_of(mode_q, acc_q));
          state_d = IDLE;
        end
        default: ;
      endcase
    end
  end

  assign rx_busy = (state_q != IDLE);

  // ---------------- error counter ----------------
`ifdef UART_PAR_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else if (rx_par_err && (err_cnt_q != '1)) begin
      err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
    end
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_uart_parity_unit.sv
// Self-checking bench for uart_parity_unit: TX vector table plus scoreboarded RX frames.
// Latency: checks sample 1-2 time units after the rising edge.
// Backpressure: not applicable.
module tb_uart_parity_unit;

  localparam int DW  = 8;
  localparam int ECW = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [2:0]     mode;
  logic           tx_ld;
  logic [DW-1:0]  tx_data;
  logic           tx_par;
  logic           tx_par_vld;
  logic           rx_start;
  logic           rx_bit_vld;
  logic           rx_bit;
  logic           rx_busy;
  logic           rx_done;
  logic           rx_par_err;
  logic [ECW-1:0] err_cnt;

  always #5 clk = ~clk;

  uart_parity_unit #(.DATA_WIDTH(DW), .ERR_CNT_W(ECW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mode       (mode),
    .tx_ld      (tx_ld),
    .tx_data    (tx_data),
    .tx_par     (tx_par),
    .tx_par_vld (tx_par_vld),
    .rx_start   (rx_start),
    .rx_bit_vld (rx_bit_vld),
    .rx_bit     (rx_bit),
    .rx_busy    (rx_busy),
    .rx_done    (rx_done),
    .rx_par_err (rx_par_err),
    .err_cnt    (err_cnt)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;
  bit exp_q[$];   // expected rx_par_err per frame, popped on rx_done

  task automatic check1(input string name, input logic act, input logic exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic checkn(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor.
  always @(posedge clk) begin
    #2;
    if (rx_done) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_rx_done: rx_done=1 with no frame outstanding");
      end else begin
        check1("rx_par_err", rx_par_err, exp_q.pop_front());
      end
    end else if (rx_par_err) begin
      total_cnt++;
      $display("FAIL rx_par_err_without_done: rx_par_err=1 rx_done=0");
    end
  end

  task automatic send_bit(input logic b);
    rx_bit_vld = 1'b1;
    rx_bit     = b;
    tick();
    rx_bit_vld = 1'b0;
    rx_bit     = 1'b0;
  endtask

  task automatic rx_begin(input logic [2:0] m);
    mode     = m;
    rx_start = 1'b1;
    tick();
    rx_start = 1'b0;
  endtask

  task automatic send_data(input logic [7:0] d, input int lo, input int hi);
    for (int i = lo; i < hi; i++) send_bit(d[i]);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    check1({name, "_done_seen"}, exp_q.size() == 0, 1'b1);
    exp_q.delete();
    tick();
    tick();
  endtask

  task automatic frame(input string name, input logic [2:0] m, input logic [7:0] d,
                       input logic pbit, input bit exp_err);
    exp_q.push_back(exp_err);
    rx_begin(m);
    send_data(d, 0, DW);
    send_bit(pbit);
    wait_drain(name);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [2:0]    m;
    logic [DW-1:0] d;
    logic          p;
  } tx_vec_t;

  tx_vec_t tv[8];
  int      exp_cnt[5];

  initial begin
    tv[0] = '{3'b001, 8'hA5, 1'b0};  // even, four ones
    tv[1] = '{3'b010, 8'h01, 1'b0};  // odd, one one
    tv[2] = '{3'b011, 8'h00, 1'b1};  // mark
    tv[3] = '{3'b100, 8'hFF, 1'b0};  // space
    tv[4] = '{3'b000, 8'h00, 1'b1};  // none
    tv[5] = '{3'b101, 8'h00, 1'b1};  // reserved -> none
    tv[6] = '{3'b001, 8'h07, 1'b1};  // even, three ones
    tv[7] = '{3'b010, 8'hFF, 1'b1};  // odd, eight ones
`ifdef UART_PAR_ERR_CNT_EN
    exp_cnt = '{1, 2, 3, 3, 3};
`else
    exp_cnt = '{0, 0, 0, 0, 0};
`endif

    rst_n = 1'b0; mode = 3'b000; tx_ld = 1'b0; tx_data = '0;
    rx_start = 1'b0; rx_bit_vld = 1'b0; rx_bit = 1'b0;
    tick();
    tick();
    check1("rst_tx_par", tx_par, 1'b1);
    check1("rst_tx_par_vld", tx_par_vld, 1'b0);
    check1("rst_rx_busy", rx_busy, 1'b0);
    check1("rst_rx_done", rx_done, 1'b0);
    check1("rst_rx_par_err", rx_par_err, 1'b0);
    checkn("rst_err_cnt", int'(err_cnt), 0);
    rst_n = 1'b1;
    tick();

    // TX vector table.
    for (int i = 0; i < 8; i++) begin
      mode = tv[i].m; tx_data = tv[i].d; tx_ld = 1'b1;
      tick();
      check1($sformatf("tx_par[%0d]", i), tx_par, tv[i].p);
      check1($sformatf("tx_par_vld[%0d]", i), tx_par_vld, 1'b1);
      tx_ld = 1'b0; tx_data = ~tv[i].d;
      tick();
      check1($sformatf("tx_par_vld_drop[%0d]", i), tx_par_vld, 1'b0);
      check1($sformatf("tx_par_hold[%0d]", i), tx_par, tv[i].p);
    end

    // Back-to-back loads.
    mode = 3'b001; tx_data = 8'h01; tx_ld = 1'b1;
    tick();
    check1("b2b_par0", tx_par, 1'b1);
    check1("b2b_vld0", tx_par_vld, 1'b1);
    tx_data = 8'h03;
    tick();
    check1("b2b_par1", tx_par, 1'b0);
    check1("b2b_vld1", tx_par_vld, 1'b1);
    tx_ld = 1'b0;
    tick();
    check1("b2b_vld_end", tx_par_vld, 1'b0);

    // Odd parity, 8'h07: good and bad parity bits.
    frame("odd_good", 3'b010, 8'h07, 1'b0, 1'b0);
    frame("odd_bad", 3'b010, 8'h07, 1'b1, 1'b1);
    frame("even_good", 3'b001, 8'hA5, 1'b0, 1'b0);
    frame("mark_good", 3'b011, 8'h5A, 1'b1, 1'b0);
    frame("space_bad", 3'b100, 8'h00, 1'b1, 1'b1);

    // Bits while idle are ignored.
    send_bit(1'b1);
    send_bit(1'b0);
    check1("idle_bits_busy", rx_busy, 1'b0);

    // Mode none: done one cycle after the 8th bit, no parity bit.
    exp_q.push_back(1'b0);
    rx_begin(3'b000);
    check1("none_busy_start", rx_busy, 1'b1);
    send_data(8'hFF, 0, DW - 1);
    check1("none_no_early_done", rx_done, 1'b0);
    check1("none_busy_mid", rx_busy, 1'b1);
    send_bit(1'b1);
    check1("none_done", rx_done, 1'b1);
    check1("none_busy_fall", rx_busy, 1'b0);
    wait_drain("none");

    // Restart after 4 bits: aborted frame gives no pulse.
    rx_begin(3'b001);
    send_data(8'hFF, 0, 4);
    frame("restart_data", 3'b001, 8'h03, 1'b0, 1'b0);

    // Restart from the parity state.
    rx_begin(3'b010);
    send_data(8'hFF, 0, DW);
    check1("par_state_busy", rx_busy, 1'b1);
    frame("restart_par", 3'b001, 8'h03, 1'b0, 1'b0);

    // rx_start with a coincident bit: the bit is discarded.
    exp_q.push_back(1'b0);
    mode = 3'b001; rx_start = 1'b1; rx_bit_vld = 1'b1; rx_bit = 1'b1;
    tick();
    rx_start = 1'b0; rx_bit_vld = 1'b0; rx_bit = 1'b0;
    send_data(8'h00, 0, DW);
    send_bit(1'b0);
    wait_drain("start_wins");

    // Reset while in the parity state.
    rx_begin(3'b001);
    send_data(8'h07, 0, DW);
    rst_n = 1'b0;
    tick();
    check1("rst_par_busy", rx_busy, 1'b0);
    check1("rst_par_done", rx_done, 1'b0);
    rst_n = 1'b1;
    send_bit(1'b0);
    tick();
    check1("rst_par_no_done", rx_done, 1'b0);
    frame("after_reset", 3'b001, 8'h07, 1'b1, 1'b0);

    // Mode changed mid-frame: odd latched, parity 0 is correct for 8'h07.
    exp_q.push_back(1'b0);
    rx_begin(3'b010);
    send_data(8'h07, 0, 4);
    mode = 3'b001;
    send_data(8'h07, 4, DW);
    send_bit(1'b0);
    wait_drain("mode_latch");

    // Error counter saturation (ERR_CNT_W=2).
    do_reset();
    checkn("err_cnt_cleared", int'(err_cnt), 0);
    for (int k = 0; k < 5; k++) begin
      frame($sformatf("bad_frame%0d", k), 3'b001, 8'h00, 1'b1, 1'b1);
      checkn($sformatf("err_cnt[%0d]", k), int'(err_cnt), exp_cnt[k]);
    end

    tick();
    tick();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
